// File: rtl/cmd_arbiter_pkg.sv
// Shared types and widths for the host/internal register-bus command arbiter.
package cmd_arbiter_pkg;

  localparam int ADR_W = 16;
  localparam int DAT_W = 8;
  localparam int SEQ_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_HRSP,
    ST_IACK
  } state_t;

  typedef enum logic {
    SRC_INT  = 1'b0,
    SRC_HOST = 1'b1
  } src_t;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } host_cmd_t;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [DAT_W-1:0] dat;
    logic             err;
  } rsp_t;

endpackage

// File: rtl/cmd_arbiter_fifo.sv
// Synchronous FIFO with first-word-fall-through head; a push on a full queue is dropped.
module cmd_arbiter_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cmd_arbiter.sv
// Queues host commands, arbitrates the register bus against an internal requester,
// enforces a bus timeout. Optional response cache for host retransmits: CMD_ARBITER_DEDUP_EN.
module cmd_arbiter
  import cmd_arbiter_pkg::*;
#(
  parameter int HOST_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_stb,
  input  logic [SEQ_W-1:0] host_seq,
  input  logic             host_we,
  input  logic [ADR_W-1:0] host_adr,
  input  logic [DAT_W-1:0] host_dat,
  input  logic             int_req,
  input  logic             int_we,
  input  logic [ADR_W-1:0] int_adr,
  input  logic [DAT_W-1:0] int_dat,
  output logic             int_ack,
  output logic [DAT_W-1:0] int_rdat,
  output logic             int_err,
  output logic             bus_stb,
  output logic             bus_we,
  output logic [ADR_W-1:0] bus_adr,
  output logic [DAT_W-1:0] bus_dat_o,
  input  logic [DAT_W-1:0] bus_dat_i,
  input  logic             bus_ack,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [SEQ_W-1:0] rsp_seq,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_err,
  output logic [7:0]       ovf_cnt
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state;
  state_t           state_n;
  src_t             last_grant;
  src_t             cur_src;
  logic [15:0]      tmo_cnt;
  host_cmd_t        push_cmd;
  host_cmd_t        head;
  logic             q_full;
  logic             q_empty;
  logic             q_pop;
  logic             grant_host;
  logic             grant_int;
  logic             dedup_hit;
  logic             cache_hit;
  logic             bus_done;
  logic [DAT_W-1:0] bus_rdat_c;
  logic             bus_err_c;

  assign push_cmd = {host_seq, host_we, host_adr, host_dat};

  cmd_arbiter_fifo #(
    .DEPTH   (HOST_DEPTH),
    .entry_t (host_cmd_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (host_stb),
    .din   (push_cmd),
    .pop   (q_pop),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty)
  );

  assign bus_stb    = (state == ST_BUS);
  assign rsp_valid  = (state == ST_HRSP);
  assign int_ack    = (state == ST_IACK);
  // Writes and timeouts both report 0x00 as data.
  assign bus_rdat_c = (bus_ack && !bus_we) ? bus_dat_i : '0;
  assign bus_err_c  = !bus_ack;

`ifdef CMD_ARBITER_DEDUP_EN
  rsp_t             cache;
  logic [ADR_W-1:0] cache_adr;
  logic             cache_vld;

  assign cache_hit = cache_vld && (head.seq == cache.seq);

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld <= 1'b0;
    end else if (bus_done && cur_src == SRC_HOST) begin
      cache_vld <= 1'b1;
    end else if (grant_int && int_we && int_adr == cache_adr) begin
      cache_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (bus_done && cur_src == SRC_HOST) begin
      cache     <= '{seq: rsp_seq, dat: bus_rdat_c, err: bus_err_c};
      cache_adr <= bus_adr;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    q_pop      = 1'b0;
    grant_host = 1'b0;
    grant_int  = 1'b0;
    dedup_hit  = 1'b0;
    bus_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        // With both pending, the host wins only if the internal side went last.
        if (!q_empty && (!int_req || last_grant == SRC_INT)) begin
          grant_host = 1'b1;
          q_pop      = 1'b1;
          if (cache_hit) begin
            dedup_hit = 1'b1;
            state_n   = ST_HRSP;
          end else begin
            state_n   = ST_BUS;
          end
        end else if (int_req) begin
          grant_int = 1'b1;
          state_n   = ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus_ack || tmo_cnt == TMO_LAST) begin
          bus_done = 1'b1;
          state_n  = (cur_src == SRC_HOST) ? ST_HRSP : ST_IACK;
        end
      end
      ST_HRSP: begin
        if (rsp_ready) state_n = ST_IDLE;
      end
      ST_IACK: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= SRC_INT;
      cur_src    <= SRC_INT;
      tmo_cnt    <= '0;
      ovf_cnt    <= '0;
      bus_we     <= 1'b0;
      bus_adr    <= '0;
      bus_dat_o  <= '0;
      rsp_seq    <= '0;
      rsp_dat    <= '0;
      rsp_err    <= 1'b0;
      int_rdat   <= '0;
      int_err    <= 1'b0;
    end else begin
      state   <= state_n;
      tmo_cnt <= (state == ST_BUS) ? tmo_cnt + 16'd1 : '0;
      if (host_stb && q_full) ovf_cnt <= sat_inc(ovf_cnt);

      if (grant_host) begin
        last_grant <= SRC_HOST;
        cur_src    <= SRC_HOST;
        rsp_seq    <= head.seq;
        if (!dedup_hit) begin
          bus_we    <= head.we;
          bus_adr   <= head.adr;
          bus_dat_o <= head.dat;
        end
      end
      if (grant_int) begin
        last_grant <= SRC_INT;
        cur_src    <= SRC_INT;
        bus_we     <= int_we;
        bus_adr    <= int_adr;
        bus_dat_o  <= int_dat;
      end

      if (bus_done) begin
        if (cur_src == SRC_HOST) begin
          rsp_dat <= bus_rdat_c;
          rsp_err <= bus_err_c;
        end else begin
          int_rdat <= bus_rdat_c;
          int_err  <= bus_err_c;
        end
      end

`ifdef CMD_ARBITER_DEDUP_EN
      if (dedup_hit) begin
        rsp_dat <= cache.dat;
        rsp_err <= cache.err;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter: host read, timeout, arbitration, overflow/backpressure,
// counter saturation, reset abort and the CMD_ARBITER_DEDUP_EN retransmit path.
module tb_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_stb;
  logic [5:0]  host_seq;
  logic        host_we;
  logic [15:0] host_adr;
  logic [7:0]  host_dat;
  logic        int_req;
  logic        int_we;
  logic [15:0] int_adr;
  logic [7:0]  int_dat;
  logic        int_ack;
  logic [7:0]  int_rdat;
  logic        int_err;
  logic        bus_stb;
  logic        bus_we;
  logic [15:0] bus_adr;
  logic [7:0]  bus_dat_o;
  logic [7:0]  bus_dat_i;
  logic        bus_ack;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [5:0]  rsp_seq;
  logic [7:0]  rsp_dat;
  logic        rsp_err;
  logic [7:0]  ovf_cnt;

  always #5 clk = ~clk;

  cmd_arbiter #(
    .HOST_DEPTH (4),
    .TIMEOUT    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host_stb  (host_stb),
    .host_seq  (host_seq),
    .host_we   (host_we),
    .host_adr  (host_adr),
    .host_dat  (host_dat),
    .int_req   (int_req),
    .int_we    (int_we),
    .int_adr   (int_adr),
    .int_dat   (int_dat),
    .int_ack   (int_ack),
    .int_rdat  (int_rdat),
    .int_err   (int_err),
    .bus_stb   (bus_stb),
    .bus_we    (bus_we),
    .bus_adr   (bus_adr),
    .bus_dat_o (bus_dat_o),
    .bus_dat_i (bus_dat_i),
    .bus_ack   (bus_ack),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_seq   (rsp_seq),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .ovf_cnt   (ovf_cnt)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_delay;
  int          stb_cyc;
  int          bus_starts;
  int          last_stb_len;
  int          int_acks;
  logic [7:0]  int_rdat_s;
  logic        int_err_s;
  logic [15:0] log_adr [$];
  logic [14:0] rsp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: record handshakes seen at the edge, then play bus slave and internal requester.
  task automatic tick();
    logic        hs;
    logic [14:0] r;
    hs = rsp_valid && rsp_ready && !rst;
    r  = {rsp_seq, rsp_dat, rsp_err};
    @(posedge clk);
    #1;
    if (hs) rsp_q.push_back(r);
    if (bus_stb) begin
      if (stb_cyc == 0) begin
        bus_starts++;
        log_adr.push_back(bus_adr);
      end
      stb_cyc++;
      bus_ack = (ack_delay > 0) && (stb_cyc == ack_delay);
    end else begin
      if (stb_cyc != 0) last_stb_len = stb_cyc;
      stb_cyc = 0;
      bus_ack = 1'b0;
    end
    if (int_ack) begin
      int_req    = 1'b0;
      int_acks++;
      int_rdat_s = int_rdat;
      int_err_s  = int_err;
    end
  endtask

  task automatic host_cmd(input logic [5:0] s, input logic we, input logic [15:0] a, input logic [7:0] d);
    host_stb = 1'b1;
    host_seq = s;
    host_we  = we;
    host_adr = a;
    host_dat = d;
    tick();
    host_stb = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    int_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 60) begin
      tick();
      n++;
    end
    check(tag, rsp_valid, 1);
  endtask

  task automatic wait_rspq(input string tag, input int sz);
    int n = 0;
    while (rsp_q.size() < sz && n < 120) begin
      tick();
      n++;
    end
    check(tag, rsp_q.size(), sz);
  endtask

  task automatic wait_int(input string tag, input int cnt);
    int n = 0;
    while (int_acks < cnt && n < 60) begin
      tick();
      n++;
    end
    check(tag, int_acks, cnt);
  endtask

  initial begin
    int          s0;
    int          b0;
    int          stable;
    logic [14:0] snap;

    rst = 1'b1; host_stb = 1'b0; host_seq = '0; host_we = 1'b0; host_adr = '0; host_dat = '0;
    int_req = 1'b0; int_we = 1'b0; int_adr = '0; int_dat = '0;
    bus_dat_i = '0; bus_ack = 1'b0; rsp_ready = 1'b0;
    ack_delay = 0; stb_cyc = 0; bus_starts = 0; last_stb_len = 0; int_acks = 0;
    int_rdat_s = '0; int_err_s = 1'b0;
    do_reset();

    // Reset state
    check("rst_bus_stb", bus_stb, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_int_ack", int_ack, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    check("rst_rsp_fields", {rsp_seq, rsp_dat, rsp_err}, 0);
    check("rst_int_err", int_err, 0);
    check("rst_bus_adr", bus_adr, 0);

    // Host read, ack on the third bus cycle
    ack_delay = 3; bus_dat_i = 8'hA5; rsp_ready = 1'b0;
    host_cmd(6'd5, 1'b0, 16'h1234, 8'h00);
    check("rd_lat_1cyc", bus_stb, 0);
    tick();
    check("rd_lat_2cyc", bus_stb, 1);
    check("rd_bus_adr", bus_adr, 16'h1234);
    check("rd_bus_we", bus_we, 0);
    wait_rsp("rd_rsp_valid");
    check("rd_rsp_seq", rsp_seq, 5);
    check("rd_rsp_dat", rsp_dat, 8'hA5);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_stb_len", last_stb_len, 3);
    rsp_ready = 1'b1;
    tick();
    check("rd_rsp_drop", rsp_valid, 0);

    // Host write with no ack: timeout after 8 cycles
    ack_delay = 0; rsp_ready = 1'b0;
    host_cmd(6'd9, 1'b1, 16'h0010, 8'h3C);
    wait_rsp("to_rsp_valid");
    check("to_stb_len", last_stb_len, 8);
    check("to_bus_adr", log_adr[log_adr.size()-1], 16'h0010);
    check("to_rsp", {rsp_seq, rsp_dat, rsp_err}, {6'd9, 8'h00, 1'b1});
    rsp_ready = 1'b1;
    tick();

    // Arbitration: host first after reset, then internal, then remaining host
    do_reset();
    rsp_q.delete(); int_acks = 0;
    ack_delay = 2; bus_dat_i = 8'h5A; rsp_ready = 1'b1;
    s0 = bus_starts; b0 = log_adr.size();
    host_cmd(6'd1, 1'b0, 16'h0100, 8'h00);
    int_we = 1'b0; int_adr = 16'hBEEF; int_dat = 8'h00; int_req = 1'b1;
    host_cmd(6'd2, 1'b0, 16'h0200, 8'h00);
    wait_rspq("arb_rsp_cnt", 2);
    check("arb_bus_cnt", bus_starts - s0, 3);
    check("arb_grant0", log_adr[b0], 16'h0100);
    check("arb_grant1", log_adr[b0+1], 16'hBEEF);
    check("arb_grant2", log_adr[b0+2], 16'h0200);
    check("arb_int_acks", int_acks, 1);
    check("arb_int_rsp", {int_rdat_s, int_err_s}, {8'h5A, 1'b0});
    check("arb_rsp0", rsp_q[0], {6'd1, 8'h5A, 1'b0});
    check("arb_rsp1", rsp_q[1], {6'd2, 8'h5A, 1'b0});

    // Overflow while a response is held back by rsp_ready
    do_reset();
    rsp_q.delete();
    ack_delay = 0; rsp_ready = 1'b0;
    host_cmd(6'd20, 1'b0, 16'h0020, 8'h00);
    wait_rsp("ovf_first_rsp");
    snap = {rsp_seq, rsp_dat, rsp_err};
    s0 = bus_starts; stable = 1;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        host_stb = 1'b1; host_seq = 6'(10 + i); host_we = 1'b0; host_adr = 16'(16'h0300 + i);
      end else begin
        host_stb = 1'b0;
      end
      tick();
      if (!rsp_valid || {rsp_seq, rsp_dat, rsp_err} !== snap) stable = 0;
    end
    host_stb = 1'b0;
    check("bp_rsp_stable", stable, 1);
    check("bp_no_bus", bus_starts - s0, 0);
    check("ovf_cnt_2", ovf_cnt, 2);
    ack_delay = 1; bus_dat_i = 8'h77; rsp_ready = 1'b1;
    wait_rspq("ovf_rsp_cnt", 5);
    check("ovf_rsp0", rsp_q[0], {6'd20, 8'h00, 1'b1});
    for (int i = 1; i < 5; i++) check("ovf_rsp_order", rsp_q[i], {6'(9 + i), 8'h77, 1'b0});
    check("ovf_cnt_hold", ovf_cnt, 2);

    // Overflow counter saturation
    do_reset();
    ack_delay = 0; rsp_ready = 1'b0;
    host_stb = 1'b1; host_seq = 6'd40;
    for (int i = 0; i < 270; i++) tick();
    host_stb = 1'b0;
    check("ovf_saturate", ovf_cnt, 8'hFF);

    // Reset mid-transaction aborts the cycle and flushes the queue
    do_reset();
    rsp_q.delete(); rsp_ready = 1'b1; ack_delay = 0;
    host_cmd(6'd30, 1'b0, 16'h0030, 8'h00);
    host_cmd(6'd31, 1'b0, 16'h0031, 8'h00);
    check("abort_in_bus", bus_stb, 1);
    rst = 1'b1;
    tick();
    check("abort_stb_drop", bus_stb, 0);
    rst = 1'b0;
    s0 = bus_starts;
    for (int i = 0; i < 15; i++) tick();
    check("abort_no_bus", bus_starts - s0, 0);
    check("abort_no_rsp", rsp_q.size(), 0);

    // Retransmitted seq=7 read, then an internal write to the same address
    do_reset();
    rsp_q.delete(); int_acks = 0;
    ack_delay = 2; bus_dat_i = 8'hC3; rsp_ready = 1'b1;
    s0 = bus_starts;
    host_cmd(6'd7, 1'b0, 16'h0042, 8'h00);
    wait_rspq("dd_rsp1", 1);
    host_cmd(6'd7, 1'b0, 16'h0042, 8'h00);
    wait_rspq("dd_rsp2", 2);
`ifdef CMD_ARBITER_DEDUP_EN
    check("dd_bus_cnt", bus_starts - s0, 1);
`else
    check("dd_bus_cnt", bus_starts - s0, 2);
`endif
    check("dd_rsp0", rsp_q[0], {6'd7, 8'hC3, 1'b0});
    check("dd_rsp1_val", rsp_q[1], {6'd7, 8'hC3, 1'b0});
    int_we = 1'b1; int_adr = 16'h0042; int_dat = 8'h11; int_req = 1'b1;
    wait_int("dd_int_ack", 1);
    host_cmd(6'd7, 1'b0, 16'h0042, 8'h00);
    wait_rspq("dd_rsp3", 3);
`ifdef CMD_ARBITER_DEDUP_EN
    check("dd_inval_bus_cnt", bus_starts - s0, 3);
`else
    check("dd_inval_bus_cnt", bus_starts - s0, 4);
`endif
    check("dd_rsp2_val", rsp_q[2], {6'd7, 8'hC3, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_arbiter.md
# cmd_arbiter

Sequences decoded serial host commands onto the shared 16-bit-address register bus and arbitrates that bus against one internal requester. Host commands arrive as single-cycle strobes from the serial message parser, are buffered in a small queue, executed one at a time with a bus timeout, and answered through a valid/ready response port that feeds the serial transmit path.

## Interface
- HOST_DEPTH, 4: host command queue depth; power of two, 2..16.
- TIMEOUT, 255: cycles to wait for bus_ack before aborting; 1..65535.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- host_stb  in  1  one-cycle pulse: new host command valid.
- host_seq  in  6  host sequence number.
- host_we  in  1  1 = write, 0 = read.
- host_adr  in  16  register address.
- host_dat  in  8  write data.
- int_req  in  1  internal request; held until int_ack.
- int_we, int_adr, int_dat  in  1/16/8  internal request fields; stable while int_req.
- int_ack  out  1  one-cycle completion pulse to the internal requester.
- int_rdat  out  8  read data; valid with int_ack.
- int_err  out  1  timeout flag; valid with int_ack.
- bus_stb  out  1  bus cycle active.
- bus_we, bus_adr, bus_dat_o  out  1/16/8  bus cycle fields; stable while bus_stb.
- bus_dat_i  in  8  read data; sampled with bus_ack.
- bus_ack  in  1  bus completion; honoured only while bus_stb.
- rsp_valid  out  1  host response pending.
- rsp_ready  in  1  transmit path accepts the response.
- rsp_seq, rsp_dat, rsp_err  out  6/8/1  response fields; stable while rsp_valid.
- ovf_cnt  out  8  saturating count of host commands dropped on a full queue.

## Operation
- Reset values: bus_stb, int_ack, rsp_valid, rsp_err, int_err = 0; bus/rsp data outputs = 0; ovf_cnt = 0; queue empty; last_grant = internal; dedup cache invalid.
- Queue: host_stb pushes {seq,we,adr,dat}. When the queue is full, the command is dropped and ovf_cnt increments, saturating at 255. A push on a full queue is dropped even if a pop occurs in the same cycle.
- FSM states: IDLE, BUS, HRSP, IACK.
- IDLE:
  - If only one source is pending, grant it.
  - If both are pending (queue non-empty and int_req), grant the source not in last_grant, then update last_grant.
  - Load the bus fields, assert bus_stb, and go to BUS. A host grant pops the queue head at grant time.
- BUS:
  - bus_ack: capture bus_dat_i and set err = 0.
  - TIMEOUT cycles elapsed without ack: set err = 1 and capture data = 0x00.
  - Either way, drop bus_stb and go to HRSP (host grant) or IACK (internal grant).
  - The timeout counter is 16 bits, clears on entering BUS, and counts every cycle in BUS.
- HRSP: assert rsp_valid with seq/dat/err, hold until rsp_ready, then go to IDLE. The queue keeps accepting pushes during this state.
- IACK: pulse int_ack for one cycle with int_rdat/int_err, then go to IDLE.
- Write cycles return rsp_dat = 0x00.

## Timing
- Grant latency: bus_stb rises 1 cycle after IDLE detects a pending request. From host_stb into an empty queue to bus_stb is 2 cycles.
- bus_ack sampled in cycle N gives bus_stb low and rsp_valid/int_ack high in cycle N+1.
- Timeout: bus_stb is high for exactly TIMEOUT cycles, then drops.
- A new bus cycle starts no earlier than 1 cycle after HRSP/IACK exits. bus_stb is low for at least 1 cycle between any two bus cycles.
- Reset in any state takes effect at the next edge:
  - bus_stb drops and queued commands are discarded.
  - No response or int_ack is produced for the aborted transaction.

## Configuration
- CMD_ARBITER_DEDUP_EN defined:
  - The block caches {seq, dat, err} of the last completed host response.
  - If the queue head's seq equals the cached seq and the cache is valid, the head is popped in IDLE and HRSP is entered directly with the cached data. No bus cycle is issued; latency is 1 cycle.
  - This makes host retransmits idempotent.
  - The cache is invalidated on reset and on any internal-granted write to the same address.
- Undefined: every host command executes on the bus; no cache storage is present.

## Structure
- Package cmd_arbiter_pkg: FSM state enum, host command struct {seq, we, adr, dat}, response struct {seq, dat, err}, width constants (ADR_W = 16, DAT_W = 8, SEQ_W = 6).
- Sub-module cmd_arbiter_fifo: synchronous FIFO parameterised by depth and entry type, with push/pop/full/empty flags. It is the only sub-module.

## Test plan
- Host read: host_stb seq=5, adr=0x1234, bus_ack after 3 cycles with bus_dat_i=0xA5 -> bus_adr=0x1234, bus_we=0, rsp_valid with seq=5, dat=0xA5, err=0.
- Timeout: TIMEOUT=8, host write adr=0x0010, no bus_ack -> bus_stb high exactly 8 cycles, response err=1, dat=0x00.
- Arbitration: int_req and a queued host command both pending for two consecutive grants -> grants alternate host/internal, starting with host after reset.
- Overflow: HOST_DEPTH=4, bus stalled, 6 host_stb pulses -> 4 queued, ovf_cnt=2, responses returned in seq order.
- Backpressure: rsp_ready low for 10 cycles -> rsp fields stable, no new bus cycle, queued host_stb accepted.
- Dedup (CMD_ARBITER_DEDUP_EN): seq=7 read twice -> exactly one bus cycle, two identical responses.
